// File: rtl/mips32_dmem_responder.sv
// Word-addressed data-memory slave for the MIPS32 MEM stage: one outstanding request,
// WAIT programmable wait states, held response. Optional `MIPS_DMEM_WR_PROTECT_EN` write-protects words below PROT_LIMIT.
module mips32_dmem_responder #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10,
  parameter int WAIT       = 2,
  parameter int PROT_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

`ifdef MIPS_DMEM_WR_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Not reset: contents survive rst_n so benches and software can preload it.
  logic [31:0] Mem [0:DEPTH-1];

  logic oor, prot, do_access, mem_we;

  assign oor       = |addr_q[31:ADDR_W];
  assign prot      = PROT_EN && we_q && (addr_q < 32'(PROT_LIMIT));
  assign do_access = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we    = do_access && we_q && !oor && !prot;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = (we_q || oor) ? 32'd0 : Mem[addr_q[ADDR_W-1:0]];
          err_d   = oor || prot;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) Mem[addr_q[ADDR_W-1:0]] <= wdata_q;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mips32_dmem_responder.sv
// Scoreboard bench for mips32_dmem_responder: directed cases plus randomized traffic
// checked against an array-based memory model.
module tb_mips32_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAIT  = 2;
  localparam int PROT  = 64;
`ifdef MIPS_DMEM_WR_PROTECT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  mips32_dmem_responder #(.DEPTH(DEPTH), .ADDR_W(10), .WAIT(WAIT), .PROT_LIMIT(PROT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          checks = 0, failures = 0;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: what a serialized word memory with range check and optional protection returns.
  function automatic exp_t model(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.rdata = 32'd0;
    e.err   = 1'b0;
    if (a >= DEPTH) e.err = 1'b1;
    else if (we) begin
      if (PROT_ON && a < PROT) e.err = 1'b1;
      else model_mem[a] = d;
    end else e.rdata = model_mem[a];
    return e;
  endfunction

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input bit track);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (track) exp_q.push_back(model(we, a, d));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops one expectation per completed response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (req_ready) chk("req_ready_during_rsp", 32'(req_ready), 32'd0);
        if (rsp_ready) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) rsp_ready = 1'($urandom);
  end

  initial begin
    int k;
    logic [31:0] hold, old10;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = $urandom;
      dut.Mem[i]   = model_mem[i];
    end
    model_mem[200] = 32'd7;
    dut.Mem[200]   = 32'd7;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; rsp_ready = 1'b1;

    // Latency: valid WAIT+1 cycles after acceptance.
    issue(1'b0, 32'd200, 32'd0, 1'b1);
    k = 0;
    while (k < 50) begin @(negedge clk); if (rsp_valid) break; k++; end
    chk("load_latency", 32'(k), 32'(WAIT + 1));
    @(negedge clk);
    chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
    drain();

    issue(1'b1, 32'd198, 32'd5040, 1'b1);
    issue(1'b0, 32'd198, 32'd0, 1'b1);
    drain();

    // Backpressure: response held, new request ignored.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    issue(1'b0, 32'd198, 32'd0, 1'b1);
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    hold = rsp_rdata;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd300; req_wdata = 32'd1; end
      if (i == 1) req_valid = 1'b0;
      @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_rdata", rsp_rdata, hold);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();
    chk("stall_pulse_no_write", dut.Mem[300], model_mem[300]);

    issue(1'b0, 32'h400, 32'd0, 1'b1);
    issue(1'b1, 32'h40A, 32'hBEEF, 1'b1);
    drain();
    chk("oor_mem10_unchanged", dut.Mem[10], model_mem[10]);

    // Reset one cycle after accepting a store: store dropped, array kept.
    old10 = model_mem[10];
    issue(1'b1, 32'd10, 32'hDEAD, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (WAIT + 3) @(negedge clk);
    chk("midrst_mem10_kept", dut.Mem[10], old10);
    issue(1'b0, 32'd10, 32'd0, 1'b1);
    drain();

    issue(1'b1, 32'd5, 32'h1234, 1'b1);
    issue(1'b1, 32'd64, 32'h5678, 1'b1);
    issue(1'b1, 32'd63, 32'h9ABC, 1'b1);
    drain();
    chk("prot_mem5", dut.Mem[5], model_mem[5]);
    chk("prot_mem63", dut.Mem[63], model_mem[63]);
    chk("prot_mem64", dut.Mem[64], model_mem[64]);

    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h400 + $urandom_range(0, 4095);
      else if (r == 1) a = $urandom | 32'h8000_0000;
      else if (r < 5)  a = 32'($urandom_range(56, 72));
      else             a = 32'($urandom_range(1016, 1023));
      issue(1'($urandom), a, $urandom, 1'b1);
    end
    @(posedge clk);
    #1 rand_rdy = 1'b0; rsp_ready = 1'b1;
    drain();
    for (int i = 56; i <= 72; i++) chk("rand_mem_final", dut.Mem[i], model_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
